// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a per-frame input snapshot,
// a blank anti-ghost cycle at the start of every digit slot and registered outputs.
module seg7_scan_driver #(
   parameter int CLK_FREQ   = 100000000,
   parameter int REFRESH_HZ = 250
) (
   input  logic       clk,
   input  logic       init_regs,
   input  logic [7:0] time_reading,
   input  logic [7:0] aux_reading,
   input  logic       count_enabled,
   input  logic       blank_lead,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int DWELL = CLK_FREQ / (4 * REFRESH_HZ);
   localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

   generate
      if (DWELL < 2) begin : g_dwell_check
         $error("seg7_scan_driver: DWELL must be at least 2");
      end
   endgenerate

   logic [DW-1:0] dwell_reg;
   logic [1:0]    index_reg;
   logic [7:0]    snap_time_reg;
   logic [7:0]    snap_aux_reg;
   logic          snap_ce_reg;
   logic          snap_bl_reg;
   logic [3:0]    an_reg;
   logic [6:0]    seg_reg;
   logic          dp_reg;

   logic          dwell_last;
   logic          frame_end;
   logic [3:0]    digit_val;
   logic          blank_digit;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      dwell_last  = (dwell_reg == DWELL_LAST);
      frame_end   = dwell_last && (index_reg == 2'd3);
      digit_val   = snap_time_reg[3:0];
      blank_digit = 1'b0;
      case (index_reg)
         2'd0: digit_val = snap_time_reg[3:0];
         2'd1: digit_val = snap_time_reg[7:4];
         2'd2: begin
            digit_val   = snap_aux_reg[3:0];
            blank_digit = snap_bl_reg && (snap_aux_reg == 8'h00);
         end
         default: begin
            digit_val   = snap_aux_reg[7:4];
            blank_digit = snap_bl_reg && (snap_aux_reg[7:4] == 4'h0);
         end
      endcase
   end

   // Dwell 0 of every slot is a dark cycle so the previous digit cannot ghost.
   always_comb begin
      an_next  = 4'b1111;
      seg_next = 7'b1111111;
      dp_next  = 1'b1;
      if (dwell_reg != '0) begin
         an_next  = ~(4'b0001 << index_reg);
         seg_next = blank_digit ? 7'b1111111 : decode(digit_val);
         dp_next  = !((index_reg == 2'd2) && snap_ce_reg);
      end
   end

   always_ff @(posedge clk or negedge init_regs) begin
      if (!init_regs) begin
         dwell_reg     <= '0;
         index_reg     <= 2'd0;
         snap_time_reg <= 8'h00;
         snap_aux_reg  <= 8'h00;
         snap_ce_reg   <= 1'b0;
         snap_bl_reg   <= 1'b0;
         an_reg        <= 4'b1111;
         seg_reg       <= 7'b1111111;
         dp_reg        <= 1'b1;
      end else begin
         if (dwell_last) begin
            dwell_reg <= '0;
            index_reg <= index_reg + 2'd1;
         end else begin
            dwell_reg <= dwell_reg + 1'b1;
         end
         // Inputs are captured only at the frame boundary so a frame never tears.
         if (frame_end) begin
            snap_time_reg <= time_reading;
            snap_aux_reg  <= aux_reading;
            snap_ce_reg   <= count_enabled;
            snap_bl_reg   <= blank_lead;
         end
         an_reg  <= an_next;
         seg_reg <= seg_next;
         dp_reg  <= dp_next;
      end
   end

   assign an  = an_reg;
   assign seg = seg_reg;
   assign dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Table-driven bench for seg7_scan_driver at DWELL=20: each vector is shown for a
// whole frame and every output cycle of that frame is compared.
module tb_seg7_scan_driver;

   localparam int CLK_FREQ   = 80;
   localparam int REFRESH_HZ = 1;
   localparam int SLOT       = 20;
   localparam int FRAME      = 80;

   logic       clk = 1'b0;
   logic       init_regs;
   logic [7:0] time_reading;
   logic [7:0] aux_reading;
   logic       count_enabled;
   logic       blank_lead;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] t;
      logic [7:0] a;
      logic       ce;
      logic       bl;
      logic [6:0] s0;
      logic [6:0] s1;
      logic [6:0] s2;
      logic [6:0] s3;
      logic       dp2;
   } vec_t;

   localparam int NVEC = 9;
   vec_t vecs [NVEC];
   vec_t zero_v, v37, v38, v42;

   seg7_scan_driver #(
      .CLK_FREQ   (CLK_FREQ),
      .REFRESH_HZ (REFRESH_HZ)
   ) dut (
      .clk           (clk),
      .init_regs     (init_regs),
      .time_reading  (time_reading),
      .aux_reading   (aux_reading),
      .count_enabled (count_enabled),
      .blank_lead    (blank_lead),
      .an            (an),
      .seg           (seg),
      .dp            (dp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic compare(input string name, input int cyc, input logic [3:0] e_an,
                          input logic [6:0] e_seg, input logic e_dp);
      checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
         errors++;
         $display("FAIL %s cyc=%0d got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                  name, cyc, an, seg, dp, e_an, e_seg, e_dp);
      end
   endtask

   task automatic apply(input vec_t v);
      time_reading  = v.t;
      aux_reading   = v.a;
      count_enabled = v.ce;
      blank_lead    = v.bl;
   endtask

   // Checks nticks output cycles of a frame, assuming the last edge closed a frame.
   task automatic check_frame(input vec_t v, input string name, input int nticks,
                              input int chg_at, input logic [7:0] chg_time);
      int         err0;
      int         q;
      int         idx;
      logic [3:0] one;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      err0 = errors;
      one  = 4'b0001;
      for (int k = 1; k <= nticks; k++) begin
         tick();
         q   = k - 1;
         idx = q / SLOT;
         if ((q % SLOT) == 0) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
            e_dp  = 1'b1;
         end else begin
            e_an = ~(one << idx);
            case (idx)
               0:       e_seg = v.s0;
               1:       e_seg = v.s1;
               2:       e_seg = v.s2;
               default: e_seg = v.s3;
            endcase
            e_dp = (idx == 2) ? v.dp2 : 1'b1;
         end
         compare(name, k, e_an, e_seg, e_dp);
         if (k == chg_at) time_reading = chg_time;
      end
      $display("frame %s: time=%h aux=%h ce=%b bl=%b cycles=%0d errors=%0d",
               name, v.t, v.a, v.ce, v.bl, nticks, errors - err0);
   endtask

   task automatic check_reset(input string name, input int cyc);
      compare(name, cyc, 4'b1111, 7'b1111111, 1'b1);
   endtask

   initial begin
      zero_v  = '{8'h00, 8'h00, 1'b0, 1'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 1'b1};
      vecs[0] = '{8'h37, 8'h12, 1'b1, 1'b0, 7'b1111000, 7'b0110000, 7'b0100100, 7'b1111001, 1'b0};
      vecs[1] = '{8'h37, 8'h05, 1'b0, 1'b1, 7'b1111000, 7'b0110000, 7'b0010010, 7'b1111111, 1'b1};
      vecs[2] = '{8'h37, 8'h00, 1'b1, 1'b1, 7'b1111000, 7'b0110000, 7'b1111111, 7'b1111111, 1'b0};
      vecs[3] = '{8'h37, 8'h00, 1'b0, 1'b0, 7'b1111000, 7'b0110000, 7'b1000000, 7'b1000000, 1'b1};
      vecs[4] = '{8'h3C, 8'h12, 1'b1, 1'b0, 7'b0111111, 7'b0110000, 7'b0100100, 7'b1111001, 1'b0};
      vecs[5] = '{8'h89, 8'h46, 1'b1, 1'b1, 7'b0010000, 7'b0000000, 7'b0000010, 7'b0011001, 1'b0};
      vecs[6] = '{8'h00, 8'h50, 1'b0, 1'b1, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010, 1'b1};
      vecs[7] = '{8'hAB, 8'hF0, 1'b0, 1'b1, 7'b0111111, 7'b0111111, 7'b1000000, 7'b0111111, 1'b1};
      vecs[8] = '{8'h16, 8'h07, 1'b1, 1'b1, 7'b0000010, 7'b1111001, 7'b1111000, 7'b1111111, 1'b0};
      v37     = '{8'h37, 8'h12, 1'b1, 1'b0, 7'b1111000, 7'b0110000, 7'b0100100, 7'b1111001, 1'b0};
      v38     = '{8'h38, 8'h12, 1'b1, 1'b0, 7'b0000000, 7'b0110000, 7'b0100100, 7'b1111001, 1'b0};
      v42     = '{8'h42, 8'h99, 1'b0, 1'b1, 7'b0100100, 7'b0011001, 7'b0010000, 7'b0010000, 1'b1};

      // Asynchronous reset must take effect before any clock edge.
      init_regs = 1'b1;
      apply(vecs[0]);
      #1 init_regs = 1'b0;
      #1 check_reset("reset_async", 0);

      for (int i = 1; i <= 50; i++) begin
         time_reading  = 8'($urandom);
         aux_reading   = 8'($urandom);
         count_enabled = 1'($urandom);
         blank_lead    = 1'($urandom);
         tick();
         check_reset("reset_hold", i);
      end
      $display("reset hold: 50 cycles checked, errors=%0d", errors);

      @(negedge clk);
      init_regs = 1'b1;

      // First frame shows the cleared snapshot; each later frame shows the previous inputs.
      apply(vecs[0]);
      check_frame(zero_v, "first_frame", FRAME, -1, 8'h00);
      for (int i = 0; i < NVEC; i++) begin
         if (i + 1 < NVEC) apply(vecs[i + 1]);
         else apply(v37);
         check_frame(vecs[i], $sformatf("vec%0d", i), FRAME, -1, 8'h00);
      end

      // Mid-frame input change while digit 1 is scanning must not tear the frame.
      check_frame(v37, "tear_hold", FRAME, 30, 8'h38);
      check_frame(v38, "tear_next", FRAME, -1, 8'h00);

      // Reset at index 2, dwell 7 abandons the frame and the pending inputs.
      apply(v42);
      check_frame(v38, "pre_reset", 47, -1, 8'h00);
      init_regs = 1'b0;
      #1 check_reset("reset_mid", 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_reset("reset_mid_hold", i);
      end
      @(negedge clk);
      init_regs = 1'b1;
      check_frame(zero_v, "after_reset", FRAME, -1, 8'h00);
      check_frame(v42, "after_reset_load", FRAME, -1, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter REFRESH_HZ, default 250, full 4-digit frame rate in Hz; DWELL = CLK_FREQ/(4*REFRESH_HZ) cycles per digit slot.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 init_regs  input  1  reset, asynchronous, active-low.
REQ-005 time_reading  input  8  Counter output, BCD; [7:4] tens of seconds, [3:0] ones of seconds.
REQ-006 aux_reading  input  8  BCD for left digit pair; [7:4] digit 3, [3:0] digit 2; tie 0 if unused.
REQ-007 count_enabled  input  1  Counter run status; drives the separator point.
REQ-008 blank_lead  input  1  1 = leading-zero blanking on digits 3 and 2.
REQ-009 an  output  4  digit anodes, active-low, an[0] = rightmost digit.
REQ-010 seg  output  7  cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a.
REQ-011 dp  output  1  decimal point cathode, active-low.

Function
REQ-012 Dwell counter SHALL count 0..DWELL-1 and wrap to 0; digit index SHALL advance 0->1->2->3->0 on each dwell wrap.
REQ-013 DWELL < 2 SHALL be a compile-time error (elaboration $error or equivalent).
REQ-014 Snapshot register {aux_reading, time_reading, count_enabled, blank_lead} SHALL load only on the cycle where index=3 and dwell=DWELL-1; display SHALL use the snapshot only, so input changes mid-frame never tear the display.
REQ-015 Digit values: index 0 = snap time[3:0], 1 = time[7:4], 2 = aux[3:0], 3 = aux[7:4].
REQ-016 an, seg, dp SHALL be registered and lag the internal index/dwell state by exactly one clock.
REQ-017 Anti-ghost gap: at dwell=0, an SHALL be 4'b1111, seg 7'b1111111, dp 1.
REQ-018 At dwell 1..DWELL-1, an SHALL be one-hot-low on the indexed digit.
REQ-019 Decode (seg, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Non-BCD nibble (A-F) SHALL display dash: seg=0111111.
REQ-021 With snap blank_lead=1: digit 3 blanked (seg=1111111, anode still driven) when its value is 0; digit 2 blanked when digits 3 and 2 are both 0; digits 1,0 never blanked.
REQ-022 dp SHALL be 0 only during active cycles of digit 2 with snap count_enabled=1; 1 otherwise.

Reset
REQ-023 init_regs=0 SHALL, without a clock edge, force an=1111, seg=1111111, dp=1, dwell=0, index=0, snapshot=0.
REQ-024 First clock after release SHALL start a digit-0 slot at dwell=0; the first frame SHALL display the zero snapshot (00 on digits 1,0; digits 3,2 show 0 or blank per snap blank_lead=0).
REQ-025 Reset asserted mid-frame SHALL abandon the frame; no partial snapshot load.

Verification (CLK_FREQ=80, REFRESH_HZ=1, DWELL=20)
REQ-026 init_regs=0 held 50 cycles, inputs toggling -> an=1111, seg=1111111, dp=1 throughout.
REQ-027 time=8'h37, aux=8'h12, blank_lead=0, count_enabled=1 -> second frame: an=1110 seg=1111000; an=1101 seg=0110000; an=1011 seg=0100100 dp=0; an=0111 seg=1111001; each for 19 cycles after a 1-cycle 1111 gap.
REQ-028 time changes 8'h37->8'h38 while index=1 -> digit 0 still 1111000 for rest of frame; 0000000 from next frame.
REQ-029 blank_lead=1, aux=8'h05 -> digit 3 seg=1111111, digit 2 seg=0010010; aux=8'h00 -> both blank; aux=8'h00, blank_lead=0 -> both 1000000.
REQ-030 time=8'h3C -> digit 0 seg=0111111, digit 1 seg=0110000.
REQ-031 init_regs pulsed low at index=2, dwell=7 -> outputs reset immediately; after release, gap then digit 0, one-clock output lag preserved.
